exception_sequencer: RTL
========================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, giving the memory read latency in cycles, legal range 1..4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port exc_opcode, input, 1 bit: nonexistent-opcode exception request, level, sampled only in IDLE.
REQ-005 The block SHALL have port exc_overflow, input, 1 bit: ALU overflow exception request, level, sampled only in IDLE.
REQ-006 The block SHALL have port exc_div0, input, 1 bit: divide-by-zero exception request, level, sampled only in IDLE.
REQ-007 The block SHALL have port pc_atual, input, 32 bits: current PC value.
REQ-008 The block SHALL have port mem_data_out, input, 32 bits: memory read data.
REQ-009 The block SHALL have port mux_addr, output, 3 bits: select for the memory-address mux (000 PC, 011 addr 253, 100 addr 254, 101 addr 255).
REQ-010 The block SHALL have port epc_wr, output, 1 bit: EPC write enable.
REQ-011 The block SHALL have port epc_data, output, 32 bits: value to write into EPC.
REQ-012 The block SHALL have port pc_wr, output, 1 bit: PC write enable.
REQ-013 The block SHALL have port pc_data, output, 32 bits: handler address to write into PC.
REQ-014 The block SHALL have port cause, output, 2 bits: latched cause (00 none, 01 opcode, 10 overflow, 11 div0).
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port exc_ack, output, 1 bit: one-cycle pulse on sequence completion.

Function
REQ-017 The FSM SHALL have states IDLE, SAVE_EPC, WAIT, LOAD_PC, with Moore outputs decoded from the state and the cause register.
REQ-018 In IDLE, the block SHALL capture cause on the rising edge at which any enabled request is high, with priority opcode > overflow > div0, and go to SAVE_EPC.
REQ-019 In SAVE_EPC, the block SHALL hold epc_wr=1 and epc_data=pc_atual-4 (modulo 2^32), drive mux_addr to the cause vector (01->011, 10->100, 11->101), and go to WAIT on the next edge.
REQ-020 WAIT SHALL last exactly MEM_LAT cycles, using a down-counter loaded on entry; mux_addr SHALL hold the vector code and epc_wr SHALL be 0.
REQ-021 In LOAD_PC, the block SHALL hold pc_wr=1, pc_data={24'b0, mem_data_out[7:0]}, exc_ack=1 and mux_addr at the vector code, then go to IDLE.
REQ-022 Total latency SHALL be as follows: capture edge N; SAVE_EPC in cycle N+1; pc_wr high in cycle N+2+MEM_LAT (cycle N+3 for MEM_LAT=1).
REQ-023 Requests asserted while busy=1 SHALL be ignored and not queued; a request still high on return to IDLE starts a new sequence.
REQ-024 Simultaneous requests SHALL be resolved by REQ-018 priority only; lower-priority requests are dropped.
REQ-025 In IDLE, outputs SHALL be mux_addr=000, epc_wr=0, pc_wr=0, exc_ack=0, busy=0, pc_data=0 and epc_data=0; cause SHALL retain its last value.
REQ-026 epc_wr and pc_wr SHALL never be high in the same cycle.

Reset
REQ-027 reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, cause=00, the WAIT counter to 0 and all outputs to their REQ-025 values, including mid-sequence.
REQ-028 After reset_n rises, the first capture SHALL occur on the first rising edge at which a request is high.

Configuration
REQ-029 With macro EXC_DIV0_EN defined, exc_div0 SHALL be handled per REQ-018 with vector code 101.
REQ-030 Without EXC_DIV0_EN, exc_div0 SHALL be ignored, cause 11 and mux_addr 101 SHALL never occur, and the port SHALL remain present.

Verification
REQ-031 Scenario: MEM_LAT=1, pc_atual=0x0000_0040, exc_overflow pulse, mem_data_out=0x0000_00A7 -> epc_wr with epc_data 0x3C in cycle N+1; mux_addr=100 in cycles N+1..N+3; pc_wr with pc_data 0xA7 and exc_ack in cycle N+3; cause=10.
REQ-032 Scenario: all three requests high together -> cause=01, mux_addr=011, pc_data from mem byte 0xFF of word 0x1234_56FF equals 0xFF.
REQ-033 Scenario: MEM_LAT=3, exc_div0 with EXC_DIV0_EN defined -> busy high for exactly 5 cycles, pc_wr in cycle N+5; without the macro -> busy stays 0.
REQ-034 Scenario: exc_opcode held high for 10 cycles, MEM_LAT=1 -> two back-to-back sequences, second capture on the edge ending the first LOAD_PC cycle plus one IDLE cycle.
REQ-035 Scenario: reset_n driven low during WAIT -> same-cycle busy=0 and mux_addr=000, no pc_wr ever issued for that sequence, cause=00.
REQ-036 Scenario: pc_atual=0x0000_0000 -> epc_data=0xFFFF_FFFC (wrap-around).

Source files
------------

// File: rtl/exception_sequencer.sv
// Exception sequencer: on a request, saves PC-4 into EPC, waits for the vector
// memory read, then loads the handler byte into PC. Optional macro: EXC_DIV0_EN.
module exception_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_atual,
  input  logic [31:0] mem_data_out,
  output logic [2:0]  mux_addr,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        exc_ack
);

  typedef enum logic [1:0] {IDLE, SAVE_EPC, WAIT, LOAD_PC} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

  state_t      state, state_next;
  logic [1:0]  wait_cnt, wait_cnt_next;
  logic [1:0]  cause_next;
  logic [2:0]  vec_code;
  logic        div0_req;
  logic [23:0] unused_mem_hi;

`ifdef EXC_DIV0_EN
  assign div0_req = exc_div0;
`else
  logic unused_div0;
  assign unused_div0 = exc_div0;
  assign div0_req    = 1'b0;
`endif

  // Only the low byte of the vector word is a handler address.
  assign unused_mem_hi = mem_data_out[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      cause    <= 2'b00;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      cause    <= cause_next;
    end
  end

  always_comb begin
    vec_code = 3'b000;
    case (cause)
      2'b01:   vec_code = 3'b011;
      2'b10:   vec_code = 3'b100;
      2'b11:   vec_code = 3'b101;
      default: vec_code = 3'b000;
    endcase
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    cause_next    = cause;
    mux_addr      = 3'b000;
    epc_wr        = 1'b0;
    epc_data      = 32'd0;
    pc_wr         = 1'b0;
    pc_data       = 32'd0;
    busy          = 1'b1;
    exc_ack       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Fixed priority; lower-priority simultaneous requests are dropped.
        if (exc_opcode) begin
          cause_next = 2'b01;
          state_next = SAVE_EPC;
        end else if (exc_overflow) begin
          cause_next = 2'b10;
          state_next = SAVE_EPC;
        end else if (div0_req) begin
          cause_next = 2'b11;
          state_next = SAVE_EPC;
        end
      end
      SAVE_EPC: begin
        epc_wr        = 1'b1;
        epc_data      = pc_atual - 32'd4;
        mux_addr      = vec_code;
        wait_cnt_next = WAIT_LOAD;
        state_next    = WAIT;
      end
      WAIT: begin
        mux_addr = vec_code;
        if (wait_cnt == 2'd0) begin
          state_next = LOAD_PC;
        end else begin
          wait_cnt_next = wait_cnt - 2'd1;
        end
      end
      LOAD_PC: begin
        pc_wr      = 1'b1;
        pc_data    = {24'd0, mem_data_out[7:0]};
        exc_ack    = 1'b1;
        mux_addr   = vec_code;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
